bit_stream_source: RTL

Serial input stage that feeds the sequence-detector `FSM`. It turns raw board inputs (bit switch, step push-button, auto/manual mode switch) into a clean stream of single bits. Each bit is presented on `in_bit` with a one-cycle `bit_stb` qualifier, which the FSM uses as its clock enable. In auto mode the bits come from an internal 8-bit LFSR at a fixed rate instead. It also exports a 4-bit history and an emitted-bit count for display and debug.

---
 rtl/bit_stream_source.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/bit_stream_source.sv
// Serial bit source for the sequence detector: synchronizes and debounces board inputs,
// emitting one qualified bit per button press (manual) or per LFSR period (auto).
module bit_stream_source #(
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter int         AUTO_PERIOD     = 8,
    parameter logic [7:0] LFSR_SEED       = 8'hA5
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       sw_bit,
    input  logic       step_btn,
    input  logic       auto_mode,
    output logic       in_bit,
    output logic       bit_stb,
    output logic [3:0] history,
    output logic [7:0] bit_count
);

    localparam int               DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int               PER_W    = $clog2(AUTO_PERIOD);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(AUTO_PERIOD - 1);
    localparam logic [7:0]       SEED     = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

    logic             sw_meta_q, sw_s_q;
    logic             btn_meta_q, btn_s_q;
    logic             auto_meta_q, auto_s_q, auto_prev_q;
    logic             sw_db_q, sw_db_d;
    logic             btn_db_q, btn_db_d;
    logic             btn_prev_q;
    logic [DB_W-1:0]  sw_cnt_q, sw_cnt_d;
    logic [DB_W-1:0]  btn_cnt_q, btn_cnt_d;
    logic [PER_W-1:0] per_q, per_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic             in_bit_q, in_bit_d;
    logic             bit_stb_q, bit_stb_d;
    logic [3:0]       history_q, history_d;
    logic [7:0]       bit_count_q, bit_count_d;
    logic             mode_chg;
    logic             emit;
    logic             emit_val;

    // Debounced value flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        sw_db_d   = sw_db_q;
        sw_cnt_d  = sw_cnt_q;
        btn_db_d  = btn_db_q;
        btn_cnt_d = btn_cnt_q;
        if (sw_s_q == sw_db_q) begin
            sw_cnt_d = '0;
        end else if (sw_cnt_q == DB_LAST) begin
            sw_db_d  = ~sw_db_q;
            sw_cnt_d = '0;
        end else begin
            sw_cnt_d = sw_cnt_q + DB_W'(1);
        end
        if (btn_s_q == btn_db_q) begin
            btn_cnt_d = '0;
        end else if (btn_cnt_q == DB_LAST) begin
            btn_db_d  = ~btn_db_q;
            btn_cnt_d = '0;
        end else begin
            btn_cnt_d = btn_cnt_q + DB_W'(1);
        end
    end

    always_comb begin
        mode_chg = (auto_s_q != auto_prev_q);
        emit     = 1'b0;
        emit_val = 1'b0;
        per_d    = per_q;
        lfsr_d   = lfsr_q;
        if (mode_chg) begin
            per_d = '0;
        end else if (auto_s_q) begin
            if (per_q == PER_LAST) begin
                per_d    = '0;
                emit     = 1'b1;
                emit_val = lfsr_q[0];
                lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            end else begin
                per_d = per_q + PER_W'(1);
            end
        end else begin
            per_d = '0;
            if (btn_db_q && !btn_prev_q) begin
                emit     = 1'b1;
                emit_val = sw_db_q;
            end
        end
    end

    always_comb begin
        in_bit_d    = in_bit_q;
        history_d   = history_q;
        bit_count_d = bit_count_q;
        bit_stb_d   = emit;
        if (emit) begin
            in_bit_d    = emit_val;
            history_d   = {history_q[2:0], emit_val};
            bit_count_d = bit_count_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            sw_meta_q   <= 1'b0;
            sw_s_q      <= 1'b0;
            btn_meta_q  <= 1'b0;
            btn_s_q     <= 1'b0;
            auto_meta_q <= 1'b0;
            auto_s_q    <= 1'b0;
            auto_prev_q <= 1'b0;
            sw_db_q     <= 1'b0;
            sw_cnt_q    <= '0;
            btn_db_q    <= 1'b0;
            btn_cnt_q   <= '0;
            btn_prev_q  <= 1'b0;
            per_q       <= '0;
            lfsr_q      <= SEED;
            in_bit_q    <= 1'b0;
            bit_stb_q   <= 1'b0;
            history_q   <= 4'b0000;
            bit_count_q <= 8'd0;
        end else begin
            sw_meta_q   <= sw_bit;
            sw_s_q      <= sw_meta_q;
            btn_meta_q  <= step_btn;
            btn_s_q     <= btn_meta_q;
            auto_meta_q <= auto_mode;
            auto_s_q    <= auto_meta_q;
            auto_prev_q <= auto_s_q;
            sw_db_q     <= sw_db_d;
            sw_cnt_q    <= sw_cnt_d;
            btn_db_q    <= btn_db_d;
            btn_cnt_q   <= btn_cnt_d;
            btn_prev_q  <= btn_db_q;
            per_q       <= per_d;
            lfsr_q      <= lfsr_d;
            in_bit_q    <= in_bit_d;
            bit_stb_q   <= bit_stb_d;
            history_q   <= history_d;
            bit_count_q <= bit_count_d;
        end
    end

    assign in_bit    = in_bit_q;
    assign bit_stb   = bit_stb_q;
    assign history   = history_q;
    assign bit_count = bit_count_q;

endmodule
